// File: rtl/vram_pkg.sv
// vram_pkg: frame-buffer geometry shared by the VGA generator, sram and arbiter
package vram_pkg;
  localparam int VRAM_ADDR_WIDTH = 15;
  localparam int VRAM_DATA_WIDTH = 8;
  localparam int VRAM_DEPTH      = 160 * 144;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_CLEAR
  } vram_state_e;
endpackage

// File: rtl/vram_wr_fifo.sv
// vram_wr_fifo: show-ahead write buffer holding {addr, pixel} entries
module vram_wr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 23
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);
  localparam int LP_AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [LP_AW:0]   r_wr_ptr;
  logic [LP_AW:0]   r_rd_ptr;

  assign o_data  = r_mem[r_rd_ptr[LP_AW-1:0]];
  assign o_empty = r_wr_ptr == r_rd_ptr;
  assign o_full  = (r_wr_ptr[LP_AW] != r_rd_ptr[LP_AW]) &&
                   (r_wr_ptr[LP_AW-1:0] == r_rd_ptr[LP_AW-1:0]);

  // pointers carry an extra wrap bit so full and empty are distinguishable
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push && !o_full) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop && !o_empty) r_rd_ptr <= r_rd_ptr + 1'b1;
    end

  // storage needs no reset: an empty pointer pair hides stale entries
  always_ff @(posedge i_clk)
    if (i_push && !o_full) r_mem[r_wr_ptr[LP_AW-1:0]] <= i_data;
endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: one SRAM access per cycle shared by scanout reads, buffered writes and a clear sweep
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int ADDR_WIDTH = VRAM_ADDR_WIDTH,
  parameter int DATA_WIDTH = VRAM_DATA_WIDTH,
  parameter int DEPTH      = VRAM_DEPTH,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  CLK_IN,
  input  logic                  RESET_N,
  input  logic                  RD_REQ,
  input  logic [ADDR_WIDTH-1:0] RD_ADDR,
  output logic [DATA_WIDTH-1:0] RD_DATA,
  output logic                  RD_VALID,
  input  logic                  WR_VALID,
  output logic                  WR_READY,
  input  logic [ADDR_WIDTH-1:0] WR_ADDR,
  input  logic [DATA_WIDTH-1:0] WR_DATA,
  input  logic                  CLR_START,
  input  logic [DATA_WIDTH-1:0] CLR_COLOR,
  output logic                  CLR_BUSY,
  output logic                  ERR_RANGE,
  output logic [ADDR_WIDTH-1:0] SRAM_ADDR,
  output logic                  SRAM_WE,
  output logic [DATA_WIDTH-1:0] SRAM_WDATA,
  input  logic [DATA_WIDTH-1:0] SRAM_RDATA
);
  localparam logic [ADDR_WIDTH-1:0] LP_DEPTH = ADDR_WIDTH'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LP_LAST  = ADDR_WIDTH'(DEPTH - 1);

  vram_state_e                      r_state;
  logic        [ADDR_WIDTH-1:0]     r_clr_ptr;
  logic        [DATA_WIDTH-1:0]     r_clr_color;
  logic                             r_rd_p1;
  logic                             r_rd_oor_p1;
  logic                             w_full;
  logic                             w_empty;
  logic                             w_push;
  logic                             w_pop;
  logic                             w_rd_hit;
  logic                             w_clr_slot;
  logic [ADDR_WIDTH+DATA_WIDTH-1:0] w_head;
  logic [ADDR_WIDTH-1:0]            w_head_addr;
  logic [DATA_WIDTH-1:0]            w_head_data;

  assign w_head_addr = w_head[ADDR_WIDTH+DATA_WIDTH-1:DATA_WIDTH];
  assign w_head_data = w_head[DATA_WIDTH-1:0];
  // out-of-range reads never touch the SRAM, so their slot goes to writers
  assign w_rd_hit    = RD_REQ && (RD_ADDR < LP_DEPTH);
  assign w_pop       = !w_rd_hit && !w_empty;
  assign w_clr_slot  = !w_rd_hit && w_empty && (r_state == ST_CLEAR);
  assign WR_READY    = RESET_N && !w_full && (r_state == ST_IDLE);
  assign w_push      = WR_VALID && WR_READY;
  assign CLR_BUSY    = r_state != ST_IDLE;

  vram_wr_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(ADDR_WIDTH + DATA_WIDTH)
  ) u_wr_fifo (
    .i_clk  (CLK_IN),
    .i_rst_n(RESET_N),
    .i_push (w_push),
    .i_data ({WR_ADDR, WR_DATA}),
    .i_pop  (w_pop),
    .o_data (w_head),
    .o_full (w_full),
    .o_empty(w_empty)
  );

  // per-cycle grant: scanout read, then buffered pixel, then clear sweep
  always_ff @(posedge CLK_IN or negedge RESET_N)
    if (!RESET_N) begin
      SRAM_ADDR  <= '0;
      SRAM_WE    <= 1'b0;
      SRAM_WDATA <= '0;
      ERR_RANGE  <= 1'b0;
    end else begin
      SRAM_WE <= 1'b0;
      if (w_rd_hit) SRAM_ADDR <= RD_ADDR;
      else if (w_pop) begin
        if (w_head_addr < LP_DEPTH) begin
          SRAM_ADDR  <= w_head_addr;
          SRAM_WDATA <= w_head_data;
          SRAM_WE    <= 1'b1;
        end else ERR_RANGE <= 1'b1;
      end else if (w_clr_slot) begin
        SRAM_ADDR  <= r_clr_ptr;
        SRAM_WDATA <= r_clr_color;
        SRAM_WE    <= 1'b1;
      end
    end

  // two-stage read return: SRAM data is captured the cycle after the address goes out
  always_ff @(posedge CLK_IN or negedge RESET_N)
    if (!RESET_N) begin
      r_rd_p1     <= 1'b0;
      r_rd_oor_p1 <= 1'b0;
      RD_VALID    <= 1'b0;
      RD_DATA     <= '0;
    end else begin
      r_rd_p1     <= RD_REQ;
      r_rd_oor_p1 <= RD_REQ && !w_rd_hit;
      RD_VALID    <= r_rd_p1;
      if (r_rd_p1) RD_DATA <= r_rd_oor_p1 ? '0 : SRAM_RDATA;
    end

  // clear sequencer: drain buffered pixels first, then sweep every address once
  always_ff @(posedge CLK_IN or negedge RESET_N)
    if (!RESET_N) begin
      r_state     <= ST_IDLE;
      r_clr_ptr   <= '0;
      r_clr_color <= '0;
    end else begin
      case (r_state)
        ST_IDLE:
          if (CLR_START) begin
            r_state     <= ST_DRAIN;
            r_clr_color <= CLR_COLOR;
          end
        ST_DRAIN:
          if (w_empty) begin
            r_state   <= ST_CLEAR;
            r_clr_ptr <= '0;
          end
        ST_CLEAR:
          if (w_clr_slot) begin
            if (r_clr_ptr == LP_LAST) r_state <= ST_IDLE;
            else r_clr_ptr <= r_clr_ptr + 1'b1;
          end
        default: r_state <= ST_IDLE;
      endcase
    end
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: randomized scoreboard bench for the frame-buffer arbiter
module tb_vram_arbiter;
  import vram_pkg::*;

  localparam int AW    = VRAM_ADDR_WIDTH;
  localparam int DW    = VRAM_DATA_WIDTH;
  localparam int DEPTH = VRAM_DEPTH;
  localparam int FD    = 4;

  logic          CLK_IN    = 1'b0;
  logic          RESET_N   = 1'b0;
  logic          RD_REQ    = 1'b0;
  logic [AW-1:0] RD_ADDR   = '0;
  logic          WR_VALID  = 1'b0;
  logic [AW-1:0] WR_ADDR   = '0;
  logic [DW-1:0] WR_DATA   = '0;
  logic          CLR_START = 1'b0;
  logic [DW-1:0] CLR_COLOR = '0;
  logic [DW-1:0] RD_DATA;
  logic          RD_VALID;
  logic          WR_READY;
  logic          CLR_BUSY;
  logic          ERR_RANGE;
  logic [AW-1:0] SRAM_ADDR;
  logic          SRAM_WE;
  logic [DW-1:0] SRAM_WDATA;
  logic [DW-1:0] SRAM_RDATA;

  vram_arbiter #(.FIFO_DEPTH(FD)) dut (
    .CLK_IN    (CLK_IN),
    .RESET_N   (RESET_N),
    .RD_REQ    (RD_REQ),
    .RD_ADDR   (RD_ADDR),
    .RD_DATA   (RD_DATA),
    .RD_VALID  (RD_VALID),
    .WR_VALID  (WR_VALID),
    .WR_READY  (WR_READY),
    .WR_ADDR   (WR_ADDR),
    .WR_DATA   (WR_DATA),
    .CLR_START (CLR_START),
    .CLR_COLOR (CLR_COLOR),
    .CLR_BUSY  (CLR_BUSY),
    .ERR_RANGE (ERR_RANGE),
    .SRAM_ADDR (SRAM_ADDR),
    .SRAM_WE   (SRAM_WE),
    .SRAM_WDATA(SRAM_WDATA),
    .SRAM_RDATA(SRAM_RDATA)
  );

  always #5 CLK_IN = ~CLK_IN;

  // SRAM: address registered by the arbiter, array read combinational, write on the edge
  logic [DW-1:0] mem [1 << AW];
  always @(posedge CLK_IN) if (SRAM_WE) mem[SRAM_ADDR] <= SRAM_WDATA;
  assign SRAM_RDATA = mem[SRAM_ADDR];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model: expected image, pixels accepted but not yet granted, clear progress
  typedef struct packed {logic [AW-1:0] a; logic [DW-1:0] d;} px_t;
  px_t           q[$];
  logic [DW-1:0] img [DEPTH];
  int            pred = 0;
  px_t           pred_px = '0;
  logic [AW-1:0] pred_ra = '0;
  bit            s1_v = 0, s2_v = 0, busy = 0, err = 0, ready = 0;
  logic [AW-1:0] s1_a = '0;
  logic [DW-1:0] s2_d = '0, color = '0;
  int            clr_next = 0;

  always @(negedge CLK_IN) begin
    if (!RESET_N) begin
      q.delete();
      pred = 0; s1_v = 0; s2_v = 0; busy = 0; err = 0; clr_next = 0;
    end else begin
      if (pred == 3) err = 1;
      if (pred == 1) begin
        chk("rd_slot_we", SRAM_WE, 0);
        chk("rd_slot_addr", SRAM_ADDR, pred_ra);
      end else if (pred == 2) begin
        chk("wr_we", SRAM_WE, 1);
        chk("wr_addr", SRAM_ADDR, pred_px.a);
        chk("wr_data", SRAM_WDATA, pred_px.d);
      end else if (pred == 3 || !busy) chk("idle_we", SRAM_WE, 0);
      else if (SRAM_WE) begin
        chk("clr_addr", SRAM_ADDR, clr_next);
        chk("clr_data", SRAM_WDATA, color);
        clr_next++;
        if (clr_next == DEPTH) begin
          busy = 0;
          for (int i = 0; i < DEPTH; i++) img[i] = color;
        end
      end
      chk("rd_valid", RD_VALID, s2_v);
      if (s2_v) chk("rd_data", RD_DATA, s2_d);
      s2_v = s1_v;
      s2_d = (s1_a < DEPTH) ? mem[s1_a] : '0;
      s1_v = RD_REQ;
      s1_a = RD_ADDR;
      ready = !busy && q.size() < FD;
      chk("clr_busy", CLR_BUSY, busy);
      chk("wr_ready", WR_READY, ready);
      chk("err_range", ERR_RANGE, err);
      if (RD_REQ && RD_ADDR < DEPTH) begin
        pred = 1;
        pred_ra = RD_ADDR;
      end else if (q.size() > 0) begin
        pred_px = q.pop_front();
        pred = (pred_px.a < DEPTH) ? 2 : 3;
      end else pred = 0;
      if (WR_VALID && ready) begin
        q.push_back({WR_ADDR, WR_DATA});
        if (WR_ADDR < DEPTH) img[WR_ADDR] = WR_DATA;
      end
      if (CLR_START && !busy) begin
        busy = 1;
        color = CLR_COLOR;
        clr_next = 0;
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge CLK_IN);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n = 0;
    WR_VALID = 1; WR_ADDR = a; WR_DATA = d;
    while (!WR_READY && n < 100) begin tick(); n++; end
    if (n == 100) chk("wr_timeout", 0, 1);
    tick();
    WR_VALID = 0;
  endtask

  task automatic rd(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] e);
    RD_REQ = 1; RD_ADDR = a;
    tick();
    RD_REQ = 0;
    tick();
    chk({tag, "_valid"}, RD_VALID, 1);
    chk(tag, RD_DATA, e);
  endtask

  task automatic img_cmp(input string tag);
    int bad = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== img[i]) bad++;
    chk(tag, bad, 0);
  endtask

  initial begin
    int n;
    for (int i = 0; i < (1 << AW); i++) mem[i] = DW'($urandom);
    for (int i = 0; i < DEPTH; i++) img[i] = mem[i];
    tick(3);
    chk("rst_addr", SRAM_ADDR, 0);
    chk("rst_we", SRAM_WE, 0);
    chk("rst_wdata", SRAM_WDATA, 0);
    chk("rst_rd_data", RD_DATA, 0);
    chk("rst_rd_valid", RD_VALID, 0);
    chk("rst_err", ERR_RANGE, 0);
    chk("rst_busy", CLR_BUSY, 0);
    chk("rst_ready", WR_READY, 0);
    RESET_N = 1;
    #1 chk("ready_after_rst", WR_READY, 1);
    tick(6);
    // read latency
    RD_REQ = 1; RD_ADDR = 5;
    tick();
    RD_REQ = 0;
    chk("lat_addr", SRAM_ADDR, 5);
    chk("lat_we", SRAM_WE, 0);
    chk("lat_valid_early", RD_VALID, 0);
    tick();
    chk("lat_valid", RD_VALID, 1);
    chk("lat_data", RD_DATA, img[5]);
    tick();
    chk("lat_valid_drop", RD_VALID, 0);
    // write held off by eight reads
    WR_VALID = 1; WR_ADDR = 100; WR_DATA = 8'hE3; RD_REQ = 1;
    for (int i = 0; i < 8; i++) begin
      RD_ADDR = AW'($urandom_range(0, DEPTH - 1));
      tick();
      WR_VALID = 0;
    end
    RD_REQ = 0;
    tick();
    chk("coll_we", SRAM_WE, 1);
    chk("coll_addr", SRAM_ADDR, 100);
    tick(3);
    rd("coll_rd", 100, 8'hE3);
    // fill the buffer behind continuous reads
    RD_REQ = 1; RD_ADDR = 42;
    for (int i = 0; i < FD; i++) wr(AW'(300 + i), DW'(8'h40 + i));
    chk("full_ready", WR_READY, 0);
    RD_REQ = 0;
    tick(6);
    chk("drained_ready", WR_READY, 1);
    for (int i = 0; i < FD; i++) rd("full_rd", AW'(300 + i), DW'(8'h40 + i));
    // range errors
    wr(AW'(DEPTH), 8'h77);
    tick(4);
    chk("err_sticky", ERR_RANGE, 1);
    rd("oor_rd", 30000, 0);
    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      RD_REQ = 1'($urandom_range(0, 1));
      RD_ADDR = ($urandom_range(0, 19) == 0) ? AW'($urandom_range(DEPTH, (1 << AW) - 1))
                                             : AW'($urandom_range(0, 63));
      WR_VALID = 1'($urandom_range(0, 1));
      WR_ADDR = ($urandom_range(0, 29) == 0) ? AW'(DEPTH + $urandom_range(0, 9))
                                             : AW'($urandom_range(0, 63));
      WR_DATA = DW'($urandom);
      tick();
    end
    RD_REQ = 0; WR_VALID = 0;
    tick(10);
    img_cmp("rand_image");
    chk("err_still", ERR_RANGE, 1);
    // clear with two pixels still buffered
    RD_REQ = 1; RD_ADDR = 9;
    wr(200, 8'h11);
    wr(201, 8'h22);
    RD_REQ = 0; CLR_START = 1; CLR_COLOR = 8'h1C;
    tick();
    CLR_START = 0;
    chk("clr_busy_on", CLR_BUSY, 1);
    chk("clr_ready_off", WR_READY, 0);
    n = 0;
    while (clr_next < 1000 && n < 5000) begin tick(); n++; end
    CLR_START = 1; CLR_COLOR = 8'hFF;
    tick();
    CLR_START = 0;
    n = 0;
    while (busy && n < 40000) begin
      RD_REQ = ($urandom_range(0, 9) == 0);
      RD_ADDR = AW'($urandom_range(0, DEPTH - 1));
      tick();
      n++;
    end
    RD_REQ = 0;
    if (busy) chk("clr_timeout", 0, 1);
    chk("clr_busy_off", CLR_BUSY, 0);
    tick(3);
    img_cmp("clr_image");
    rd("clr_rd", 201, 8'h1C);
    // reset in the middle of a sweep
    CLR_START = 1; CLR_COLOR = 8'h55;
    tick();
    CLR_START = 0;
    n = 0;
    while (clr_next < 500 && n < 2000) begin tick(); n++; end
    chk("mid_ptr", clr_next, 500);
    RESET_N = 0;
    #1;
    chk("mid_rst_busy", CLR_BUSY, 0);
    chk("mid_rst_we", SRAM_WE, 0);
    tick(2);
    RESET_N = 1;
    #1 chk("mid_rel_ready", WR_READY, 1);
    chk("mid_rel_busy", CLR_BUSY, 0);
    wr(7, 8'hAB);
    tick(4);
    rd("post_rst_rd", 7, 8'hAB);
    tick(3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
